irq_dispatch: RTL

IRQ_DISPATCH -- requirements
Module: irq_dispatch

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_dispatch_prio_max.sv | 51 +++++
 rtl/irq_dispatch.sv | 94 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt dispatcher.
// Imported by the dispatcher, its arbiter and the bench.
package irq_pkg;

    localparam int NUM_VECS    = 8;
    localparam int PRIO_WIDTH  = 3;
    localparam int STACK_DEPTH = 8;
    localparam int VEC_WIDTH   = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;

    typedef logic [PRIO_WIDTH-1:0] prio_t;
    typedef logic [VEC_WIDTH-1:0]  vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        RET
    } state_t;

endpackage

// File: rtl/irq_dispatch_prio_max.sv
// Combinational max-priority reduction tree over the candidate vectors.
// Ties resolve to the lowest index because left subtrees hold lower indexes.
module prio_max #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   valid_in,
    input  logic [N*W-1:0] prio_in,
    output logic           valid,
    output logic [IW-1:0]  index,
    output logic [W-1:0]   prio
);

    localparam int P     = 1 << IW;
    localparam int Nodes = 2 * P - 1;

    logic          nv [Nodes];
    logic [IW-1:0] ni [Nodes];
    logic [W-1:0]  np [Nodes];

    // Heap layout: node n has children 2n+1 (left) and 2n+2 (right).
    always_comb begin
        for (int n = 0; n < Nodes; n++) begin
            nv[n] = 1'b0;
            ni[n] = '0;
            np[n] = '0;
        end
        for (int i = 0; i < N; i++) begin
            nv[P-1+i] = valid_in[i];
            ni[P-1+i] = IW'(i);
            np[P-1+i] = prio_in[i*W +: W];
        end
        for (int n = P - 2; n >= 0; n--) begin
            if (nv[2*n+2] && (!nv[2*n+1] || np[2*n+2] > np[2*n+1])) begin
                nv[n] = 1'b1;
                ni[n] = ni[2*n+2];
                np[n] = np[2*n+2];
            end else begin
                nv[n] = nv[2*n+1];
                ni[n] = ni[2*n+1];
                np[n] = np[2*n+1];
            end
        end
    end

    assign valid = nv[0];
    assign index = ni[0];
    assign prio  = np[0];

endmodule

// File: rtl/irq_dispatch.sv
// Nested interrupt dispatcher: arbitrates pending vectors against the
// running priority and drives push/pop strobes for the priority stack.
module irq_dispatch
    import irq_pkg::*;
#(
    parameter int NumVecs    = NUM_VECS,
    parameter int PrioWidth  = PRIO_WIDTH,
    parameter int StackDepth = STACK_DEPTH,
    parameter int VecW       = (NumVecs > 1) ? $clog2(NumVecs) : 1,
    parameter int DepthW     = $clog2(StackDepth)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NumVecs-1:0]           pend,
    input  logic [NumVecs-1:0]           en,
    input  logic [NumVecs*PrioWidth-1:0] prio,
    input  logic [PrioWidth-1:0]         curr_prio,
    input  logic                         mret,
    output logic                         push,
    output logic                         pop,
    output logic [PrioWidth-1:0]         prio_out,
    output logic                         take,
    output logic [VecW-1:0]              vec_out,
    output logic [NumVecs-1:0]           clr,
    output logic [DepthW-1:0]            depth,
    output logic                         err
);

    localparam logic [DepthW-1:0] MaxDepth = DepthW'(StackDepth - 1);

    state_t               state;
    logic                 win_valid;
    logic [VecW-1:0]      win_idx;
    logic [PrioWidth-1:0] win_prio;
    logic                 dispatch;

    prio_max #(
        .N  (NumVecs),
        .W  (PrioWidth),
        .IW (VecW)
    ) u_prio_max (
        .valid_in (pend & en),
        .prio_in  (prio),
        .valid    (win_valid),
        .index    (win_idx),
        .prio     (win_prio)
    );

    // Strict compare: equal priority never preempts the running handler.
    assign dispatch = win_valid && (win_prio > curr_prio) && (depth < MaxDepth);

    assign pop = (state == IDLE) && mret && (depth != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            push     <= 1'b0;
            take     <= 1'b0;
            clr      <= '0;
            prio_out <= '0;
            vec_out  <= '0;
            depth    <= '0;
            err      <= 1'b0;
        end else begin
            push <= 1'b0;
            take <= 1'b0;
            clr  <= '0;
            unique case (state)
                IDLE: begin
                    if (mret) begin
                        if (depth != '0) begin
                            depth <= depth - DepthW'(1);
                            state <= RET;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (dispatch) begin
                        state    <= ARB;
                        push     <= 1'b1;
                        take     <= 1'b1;
                        clr      <= NumVecs'(1) << win_idx;
                        prio_out <= win_prio;
                        vec_out  <= win_idx;
                        depth    <= depth + DepthW'(1);
                    end
                end
                ARB:     state <= IDLE;
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
